// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction RAM read port, CPU issue handshake and status.
// master = fetch unit, slave = RAM/CPU side.
interface instr_fetch_unit_if;
  logic [7:0]  start_pc;
  logic        ram_rd;
  logic [7:0]  ram_addr;
  logic [15:0] ram_rdata;
  logic        cpu_waiting;
  logic [15:0] instr;
  logic        instr_valid;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [7:0]  pc;
  logic        halted;

  modport master (
    input  start_pc, ram_rdata, cpu_waiting, redirect, redirect_pc,
    output ram_rd, ram_addr, instr, instr_valid, pc, halted
  );

  modport slave (
    output start_pc, ram_rdata, cpu_waiting, redirect, redirect_pc,
    input  ram_rd, ram_addr, instr, instr_valid, pc, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end for the lab7 CPU: owns the PC, reads 16-bit words
// from a synchronous RAM, issues them with a one-cycle pulse and stops on HALT.
module instr_fetch_unit #(
  parameter int unsigned RAM_LATENCY = 1,
  parameter logic [15:0] HALT_INSTR  = 16'hE000
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_INIT, S_REQ, S_WAIT, S_DECIDE, S_ACK, S_BUSY, S_HALT
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(RAM_LATENCY - 1);

  state_t      state, state_nxt;
  logic [7:0]  pc, pc_nxt;
  logic [7:0]  ram_addr;
  logic        ram_rd;
  logic [15:0] instr;
  logic        instr_valid;
  logic        halted;
  logic [1:0]  cnt;
  logic        redir_hit;
  logic        capture;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    redir_hit = bus.redirect && (state != S_INIT) && (state != S_HALT);
    capture   = 1'b0;
    unique case (state)
      S_INIT: begin
        pc_nxt    = bus.start_pc;
        state_nxt = S_REQ;
      end
      S_REQ:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (instr == HALT_INSTR) begin
          state_nxt = S_HALT;
        end else begin
          pc_nxt    = pc + 8'd1;
          state_nxt = S_ACK;
        end
      end
      S_ACK:  state_nxt = S_BUSY;
      S_BUSY: if (bus.cpu_waiting) state_nxt = S_REQ;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_INIT;
    endcase
    // Redirect overrides everything above, including a pending capture or issue.
    if (redir_hit) begin
      pc_nxt    = bus.redirect_pc;
      state_nxt = S_REQ;
      capture   = 1'b0;
    end
  end

  // ram_rd/ram_addr are loaded on entry to S_REQ so the strobe and its address
  // are both presented to the RAM during the S_REQ cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT;
      pc          <= '0;
      ram_addr    <= '0;
      ram_rd      <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      ram_rd      <= (state_nxt == S_REQ);
      instr_valid <= (state_nxt == S_ACK);
      if (state_nxt == S_HALT) halted <= 1'b1;
      if (state_nxt == S_REQ) begin
        ram_addr <= pc_nxt;
        cnt      <= LAT_M1;
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - 2'd1;
      end
      if (capture) instr <= bus.ram_rdata;
    end
  end

  assign bus.ram_rd      = ram_rd;
  assign bus.ram_addr    = ram_addr;
  assign bus.instr       = instr;
  assign bus.instr_valid = instr_valid;
  assign bus.pc          = pc;
  assign bus.halted      = halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (RAM_LATENCY 1 and 3), each with a RAM
// model and a timeline-based reference model compared every cycle, plus directed checks.
module tb_instr_fetch_unit;

  localparam logic [15:0] HALT = 16'hE000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mem [256];

  logic       rst_a     [2];
  logic [7:0] start_a   [2];
  logic       wait_a    [2];
  logic       redir_a   [2];
  logic [7:0] rpc_a     [2];

  logic        rd_a     [2];
  logic [7:0]  addr_a   [2];
  logic [15:0] instr_a  [2];
  logic        valid_a  [2];
  logic [7:0]  pc_a     [2];
  logic        halted_a [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = (g == 0) ? 1 : 3;

    instr_fetch_unit_if bus ();
    logic rst_l;
    assign rst_l = rst_a[g];

    instr_fetch_unit #(.RAM_LATENCY(LAT), .HALT_INSTR(HALT)) dut (
      .clk   (clk),
      .rst_n (rst_l),
      .bus   (bus)
    );

    assign bus.start_pc    = start_a[g];
    assign bus.cpu_waiting = wait_a[g];
    assign bus.redirect    = redir_a[g];
    assign bus.redirect_pc = rpc_a[g];
    assign rd_a[g]     = bus.ram_rd;
    assign addr_a[g]   = bus.ram_addr;
    assign instr_a[g]  = bus.instr;
    assign valid_a[g]  = bus.instr_valid;
    assign pc_a[g]     = bus.pc;
    assign halted_a[g] = bus.halted;

    // Synchronous RAM: word read on a strobed edge appears LAT cycles later, garbage otherwise.
    logic [15:0] rp [LAT];
    always @(posedge clk) begin
      rp[0] <= bus.ram_rd ? mem[bus.ram_addr] : 16'hDEAD;
      for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
    end
    assign bus.ram_rdata = rp[LAT-1];

    // Reference model: a fetch launched for cycle 0 (the strobe cycle) captures at the end
    // of cycle LAT, issues or halts at LAT+1, and may relaunch from cycle LAT+3 on.
    logic        m_rd, m_valid, m_halted, m_init, m_live, m_go;
    logic [7:0]  m_pc, m_addr, m_npc;
    logic [15:0] m_instr, m_word;
    int          m_age;

    always_comb begin
      m_go  = 1'b0;
      m_npc = m_pc;
      if (m_init) begin
        m_go  = 1'b1;
        m_npc = start_a[g];
      end else if (!m_halted) begin
        if (redir_a[g]) begin
          m_go  = 1'b1;
          m_npc = rpc_a[g];
        end else if (m_live && m_age == LAT + 1 && m_word != HALT) begin
          m_npc = m_pc + 8'd1;
        end else if (m_live && m_age >= LAT + 3 && wait_a[g]) begin
          m_go = 1'b1;
        end
      end
    end

    always @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        m_rd <= 1'b0; m_valid <= 1'b0; m_halted <= 1'b0; m_init <= 1'b1; m_live <= 1'b0;
        m_pc <= '0; m_addr <= '0; m_instr <= '0; m_word <= '0; m_age <= 0;
      end else begin
        m_init  <= 1'b0;
        m_pc    <= m_npc;
        m_rd    <= m_go;
        m_valid <= !m_init && !m_halted && !redir_a[g] && m_live &&
                   m_age == LAT + 1 && m_word != HALT;
        if (!m_init && !m_halted && !redir_a[g] && m_live) begin
          if (m_age == LAT) m_instr <= m_word;
          if (m_age == LAT + 1 && m_word == HALT) begin
            m_halted <= 1'b1;
            m_live   <= 1'b0;
          end
        end
        if (m_go) begin
          m_addr <= m_npc;
          m_word <= mem[m_npc];
          m_live <= 1'b1;
          m_age  <= 0;
        end else begin
          m_age <= m_age + 1;
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("u%0d.ram_rd", g),      32'(bus.ram_rd),      32'(m_rd));
      chk($sformatf("u%0d.ram_addr", g),    32'(bus.ram_addr),    32'(m_addr));
      chk($sformatf("u%0d.instr", g),       32'(bus.instr),       32'(m_instr));
      chk($sformatf("u%0d.instr_valid", g), 32'(bus.instr_valid), 32'(m_valid));
      chk($sformatf("u%0d.pc", g),          32'(bus.pc),          32'(m_pc));
      chk($sformatf("u%0d.halted", g),      32'(bus.halted),      32'(m_halted));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int g);
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (valid_a[g]) return;
    end
    chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue_is(input int g, input string nm, input logic [15:0] iw, input logic [7:0] p);
    wait_valid(g);
    chk({nm, ".instr"}, 32'(instr_a[g]), 32'(iw));
    chk({nm, ".pc"}, 32'(pc_a[g]), 32'(p));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'h5A00;
    for (int g = 0; g < 2; g++) begin
      rst_a[g] = 1'b1; start_a[g] = '0; wait_a[g] = 1'b1; redir_a[g] = 1'b0; rpc_a[g] = '0;
    end
    #1;
    rst_a[0] = 1'b0; rst_a[1] = 1'b0;
    mem[0] = 16'hD045; mem[1] = 16'h1111; mem[2] = 16'h2222; mem[3] = HALT;
    cyc(2);
    chk("rst.ram_rd", 32'(rd_a[0]), 32'd0);
    chk("rst.pc", 32'(pc_a[0]), 32'd0);
    chk("rst.instr", 32'(instr_a[0]), 32'd0);
    chk("rst.valid", 32'(valid_a[0]), 32'd0);

    // First fetch at latency 1: strobe in cycle 2, issue in cycle 5.
    rst_a[0] = 1'b1;
    cyc(1);
    chk("t1.ram_rd_c2", 32'(rd_a[0]), 32'd1);
    chk("t1.ram_addr_c2", 32'(addr_a[0]), 32'h00);
    cyc(3);
    chk("t1.valid_c5", 32'(valid_a[0]), 32'd1);
    chk("t1.instr_c5", 32'(instr_a[0]), 32'hD045);
    chk("t1.pc_c5", 32'(pc_a[0]), 32'h01);

    // CPU busy for 10 cycles: no reads until cpu_waiting returns.
    wait_a[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("t2.no_rd", 32'(rd_a[0]), 32'd0);
    end
    wait_a[0] = 1'b1;
    cyc(1);
    chk("t2.rd_after_wait", 32'(rd_a[0]), 32'd1);
    chk("t2.addr_after_wait", 32'(addr_a[0]), 32'h01);

    // Run into HALT at address 3.
    issue_is(0, "t4.i1", 16'h1111, 8'h02);
    issue_is(0, "t4.i2", 16'h2222, 8'h03);
    pulses = 0;
    for (int i = 0; i < 40 && !halted_a[0]; i++) begin
      cyc(1);
      if (valid_a[0]) pulses++;
    end
    chk("t4.halted", 32'(halted_a[0]), 32'd1);
    chk("t4.no_extra_issue", 32'(pulses), 32'd0);
    chk("t4.pc", 32'(pc_a[0]), 32'h03);
    rpc_a[0] = 8'h55;
    for (int i = 0; i < 10; i++) begin
      redir_a[0] = (i % 2 == 0);
      wait_a[0]  = (i % 3 != 0);
      cyc(1);
      chk("t4.halt_no_rd", 32'(rd_a[0]), 32'd0);
      chk("t4.halt_pc", 32'(pc_a[0]), 32'h03);
    end
    redir_a[0] = 1'b0; wait_a[0] = 1'b1;

    // PC wrap from FF.
    rst_a[0] = 1'b0;
    mem[8'hFF] = 16'hA0C1; mem[0] = 16'hB2E0;
    start_a[0] = 8'hFF;
    cyc(2);
    rst_a[0] = 1'b1;
    issue_is(0, "t3.i0", 16'hA0C1, 8'h00);
    issue_is(0, "t3.i1", 16'hB2E0, 8'h01);
    rst_a[0] = 1'b0;

    // Latency 3 instance: redirect during S_WAIT abandons the read of address 0.
    mem[0] = 16'h3000; mem[8'h40] = 16'h4040; mem[8'h41] = 16'h4141;
    mem[8'h80] = 16'h8080; mem[8'h10] = 16'h1010; mem[8'h11] = 16'h1111;
    mem[8'h20] = 16'h2020;
    start_a[1] = 8'h00;
    cyc(1);
    rst_a[1] = 1'b1;
    cyc(2);
    redir_a[1] = 1'b1; rpc_a[1] = 8'h40;
    cyc(1);
    redir_a[1] = 1'b0;
    chk("t5.redir_addr", 32'(addr_a[1]), 32'h40);
    issue_is(1, "t5.i", 16'h4040, 8'h41);

    // Redirect in S_BUSY beats cpu_waiting.
    wait_a[1] = 1'b0;
    cyc(1);
    redir_a[1] = 1'b1; rpc_a[1] = 8'h80; wait_a[1] = 1'b1;
    cyc(1);
    redir_a[1] = 1'b0;
    chk("t6.busy_redir_addr", 32'(addr_a[1]), 32'h80);
    issue_is(1, "t6.i", 16'h8080, 8'h81);

    // Redirect in S_ACK: issued word stands, next fetch from 0x10.
    redir_a[1] = 1'b1; rpc_a[1] = 8'h10;
    cyc(1);
    redir_a[1] = 1'b0;
    issue_is(1, "t7.i", 16'h1010, 8'h11);

    // Redirect in S_DECIDE (6 cycles after the pulse at latency 3) cancels the issue.
    cyc(6);
    redir_a[1] = 1'b1; rpc_a[1] = 8'h20;
    cyc(1);
    redir_a[1] = 1'b0;
    chk("t8.no_issue", 32'(valid_a[1]), 32'd0);
    chk("t8.pc", 32'(pc_a[1]), 32'h20);
    issue_is(1, "t8.i", 16'h2020, 8'h21);

    // Asynchronous reset in S_WAIT, restart from a new start_pc.
    for (int i = 0; i < 20 && !rd_a[1]; i++) cyc(1);
    chk("t9.saw_rd", 32'(rd_a[1]), 32'd1);
    cyc(1);
    #1 rst_a[1] = 1'b0;
    #1;
    chk("t9.rst_rd", 32'(rd_a[1]), 32'd0);
    chk("t9.rst_addr", 32'(addr_a[1]), 32'd0);
    chk("t9.rst_instr", 32'(instr_a[1]), 32'd0);
    chk("t9.rst_valid", 32'(valid_a[1]), 32'd0);
    chk("t9.rst_pc", 32'(pc_a[1]), 32'd0);
    chk("t9.rst_halted", 32'(halted_a[1]), 32'd0);
    start_a[1] = 8'h40;
    cyc(2);
    rst_a[1] = 1'b1;
    issue_is(1, "t9.i", 16'h4040, 8'h41);
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
